// File: rtl/p2p_pkg.sv
// Shared types and constants for the p2p result collector: FSM states,
// parameter defaults and the sum-width helper.
package p2p_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } p2p_state_e;

    localparam int P2P_SIZE_DEF = 16;
    localparam int P2P_DW_DEF   = 8;
    localparam int SUM_W        = P2P_DW_DEF + $clog2(P2P_SIZE_DEF);

    function automatic int sum_w(input int size, input int dw);
        return dw + $clog2(size);
    endfunction

endpackage

// File: rtl/p2p_result_collector_if.sv
// Handshake/status bundle between a producer and the result collector.
// The max_val/max_idx signals exist only when P2P_COLLECT_MAX_EN is defined.
interface p2p_result_collector_if
    import p2p_pkg::*;
#(
    parameter int SIZE = P2P_SIZE_DEF,
    parameter int DW   = P2P_DW_DEF
);
    localparam int AW = $clog2(SIZE);
    localparam int SW = sum_w(SIZE, DW);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_done;
    logic          clear;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [SW-1:0] sum;
    logic          frame_ready;
    logic          busy;
    logic          short_err;
    logic          overrun_err;
`ifdef P2P_COLLECT_MAX_EN
    logic [DW-1:0] max_val;
    logic [AW-1:0] max_idx;
`endif

    modport slave (
        input  in_valid, in_data, in_done, clear, rd_en, rd_addr,
        output rd_data, rd_valid, sum, frame_ready, busy, short_err, overrun_err
`ifdef P2P_COLLECT_MAX_EN
        , output max_val, max_idx
`endif
    );

    modport master (
        output in_valid, in_data, in_done, clear, rd_en, rd_addr,
        input  rd_data, rd_valid, sum, frame_ready, busy, short_err, overrun_err
`ifdef P2P_COLLECT_MAX_EN
        , input max_val, max_idx
`endif
    );

endinterface

// File: rtl/p2p_result_buf.sv
// SIZE x DW result storage: one write port, registered read port and a
// synchronous clear that zeroes every entry.
module p2p_result_buf #(
    parameter int SIZE = 16,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    we_i,
    input  logic [$clog2(SIZE)-1:0] waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic                    re_i,
    input  logic [$clog2(SIZE)-1:0] raddr_i,
    output logic [DW-1:0]           rdata_o
);
    logic [DW-1:0] mem_q [SIZE];
    logic [DW-1:0] rdata_q;

    // Storage array; clear wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value when no read is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/p2p_result_collector.sv
// Collects one frame of SIZE products, keeps their exact sum and serves reads.
// Optional max tracking is enabled with P2P_COLLECT_MAX_EN.
module p2p_result_collector
    import p2p_pkg::*;
#(
    parameter int SIZE = P2P_SIZE_DEF,
    parameter int DW   = P2P_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    p2p_result_collector_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam int SW = sum_w(SIZE, DW);

    p2p_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          frame_ready_q, frame_ready_d;
    logic          busy_q, busy_d;
    logic          short_err_q, short_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          we_s;
`ifdef P2P_COLLECT_MAX_EN
    logic [DW-1:0] max_val_q, max_val_d;
    logic [AW-1:0] max_idx_q, max_idx_d;
`endif

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            sum_q         <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            short_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rd_valid_q    <= 1'b0;
`ifdef P2P_COLLECT_MAX_EN
            max_val_q     <= '0;
            max_idx_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            short_err_q   <= short_err_d;
            overrun_err_q <= overrun_err_d;
            rd_valid_q    <= rd_valid_d;
`ifdef P2P_COLLECT_MAX_EN
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
`endif
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.in_valid ? CAPTURE : IDLE;
                CAPTURE: begin
                    if (bus.in_valid) begin
                        state_d = (count_q == CW'(SIZE - 1)) ? DONE : CAPTURE;
                    end else if (bus.in_done) begin
                        state_d = DONE;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and flag updates
    always_comb begin
        count_d       = count_q;
        sum_d         = sum_q;
        short_err_d   = short_err_q;
        overrun_err_d = overrun_err_q;
        we_s          = 1'b0;
`ifdef P2P_COLLECT_MAX_EN
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
`endif
        if (bus.clear) begin
            count_d       = '0;
            sum_d         = '0;
            short_err_d   = 1'b0;
            overrun_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        we_s      = 1'b1;
                        count_d   = CW'(1);
                        sum_d     = SW'(bus.in_data);
`ifdef P2P_COLLECT_MAX_EN
                        max_val_d = bus.in_data;
                        max_idx_d = '0;
`endif
                    end else begin
                        count_d = count_q;
                    end
                end
                CAPTURE: begin
                    if (bus.in_valid) begin
                        we_s    = 1'b1;
                        count_d = count_q + CW'(1);
                        sum_d   = sum_q + SW'(bus.in_data);
`ifdef P2P_COLLECT_MAX_EN
                        // Strict compare keeps the lowest index on ties
                        if (bus.in_data > max_val_q) begin
                            max_val_d = bus.in_data;
                            max_idx_d = count_q[AW-1:0];
                        end else begin
                            max_val_d = max_val_q;
                        end
`endif
                    end else if (bus.in_done) begin
                        short_err_d = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end
                DONE: begin
                    if (bus.in_valid) begin
                        overrun_err_d = 1'b1;
                    end else begin
                        overrun_err_d = overrun_err_q;
                    end
                end
                default: count_d = '0;
            endcase
        end
        frame_ready_d = (state_d == DONE);
        busy_d        = (state_d == CAPTURE);
        rd_valid_d    = bus.rd_en && (state_q == DONE);
    end

    p2p_result_buf #(
        .SIZE (SIZE),
        .DW   (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.clear),
        .we_i    (we_s),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.in_data),
        .re_i    (rd_valid_d),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_data)
    );

    assign bus.rd_valid    = rd_valid_q;
    assign bus.sum         = sum_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.busy        = busy_q;
    assign bus.short_err   = short_err_q;
    assign bus.overrun_err = overrun_err_q;
`ifdef P2P_COLLECT_MAX_EN
    assign bus.max_val     = max_val_q;
    assign bus.max_idx     = max_idx_q;
`endif

endmodule

// File: tb/tb_p2p_result_collector.sv
// Directed bench for p2p_result_collector; read data is checked through a
// scoreboard queue, status flags directly. Covers P2P_COLLECT_MAX_EN builds.
module tb_p2p_result_collector;
    import p2p_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] sb_q[$];

    p2p_result_collector_if #(.SIZE(16), .DW(8)) bus ();

    p2p_result_collector #(.SIZE(16), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Read monitor: every rd_valid must match the oldest expected read
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: rd_valid=1 data=%0h, required no read", bus.rd_data);
                end else begin
                    logic [7:0] exp_v;
                    exp_v = sb_q.pop_front();
                    if (bus.rd_data !== exp_v) begin
                        n_err++;
                        $display("FAIL rd_data: got %0h, required %0h", bus.rd_data, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push_sample(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic read(input logic [3:0] a, input logic [7:0] exp_v);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        sb_q.push_back(exp_v);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic check_max(input logic [7:0] mv, input logic [3:0] mi);
`ifdef P2P_COLLECT_MAX_EN
        check("max_val", 32'(bus.max_val), 32'(mv));
        check("max_idx", 32'(bus.max_idx), 32'(mi));
`else
        if (mv == 8'd0 && mi == 4'd0) begin
            tick();
        end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sum"},     32'(bus.sum),         32'h0);
        check({tag, "_ready"},   32'(bus.frame_ready), 32'h0);
        check({tag, "_busy"},    32'(bus.busy),        32'h0);
        check({tag, "_short"},   32'(bus.short_err),   32'h0);
        check({tag, "_overrun"}, 32'(bus.overrun_err), 32'h0);
        check({tag, "_rdvalid"}, 32'(bus.rd_valid),    32'h0);
        check({tag, "_rddata"},  32'(bus.rd_data),     32'h0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_done  = 1'b0;
        bus.clear    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = 4'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Frame 1..16
        for (int i = 1; i <= 15; i++) push_sample(8'(i));
        check("f1_ready_early", 32'(bus.frame_ready), 32'h0);
        check("f1_busy", 32'(bus.busy), 32'h1);
        push_sample(8'd16);
        check("f1_ready", 32'(bus.frame_ready), 32'h1);
        check("f1_busy_done", 32'(bus.busy), 32'h0);
        check("f1_sum", 32'(bus.sum), 32'h088);
        check_max(8'd16, 4'd15);
        read(4'd0, 8'h01);
        read(4'd15, 8'h10);
        tick();
        do_clear();
        check("f1_clr_ready", 32'(bus.frame_ready), 32'h0);

        // All 0xFF: exact sum, tie keeps lowest index
        for (int i = 0; i < 16; i++) push_sample(8'hFF);
        check("ff_sum", 32'(bus.sum), 32'hFF0);
        check_max(8'hFF, 4'd0);
        read(4'd5, 8'hFF);
        tick();
        do_clear();

        // Short frame of 5 then in_done
        push_sample(8'd3); push_sample(8'd5); push_sample(8'd7);
        push_sample(8'd9); push_sample(8'd11);
        check("sh_short_pre", 32'(bus.short_err), 32'h0);
        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
        check("sh_short", 32'(bus.short_err), 32'h1);
        check("sh_ready", 32'(bus.frame_ready), 32'h1);
        check("sh_busy", 32'(bus.busy), 32'h0);
        check("sh_sum", 32'(bus.sum), 32'h023);
        check_max(8'd11, 4'd4);
        read(4'd7, 8'h00);
        read(4'd4, 8'h0B);
        tick();
        do_clear();

        // Full frame then overrun sample 0x55
        for (int i = 0; i < 16; i++) push_sample(8'(8'h10 + i));
        check("ov_sum", 32'(bus.sum), 32'h178);
        push_sample(8'h55);
        check("ov_flag", 32'(bus.overrun_err), 32'h1);
        check("ov_sum_hold", 32'(bus.sum), 32'h178);
        check("ov_ready", 32'(bus.frame_ready), 32'h1);
        check_max(8'h1F, 4'd15);
        read(4'd0, 8'h10);
        read(4'd15, 8'h1F);
        tick();
        check("ov_sticky", 32'(bus.overrun_err), 32'h1);
        do_clear();
        check("ov_clr_ready", 32'(bus.frame_ready), 32'h0);
        check("ov_clr_overrun", 32'(bus.overrun_err), 32'h0);
        check("ov_clr_short", 32'(bus.short_err), 32'h0);
        check("ov_clr_busy", 32'(bus.busy), 32'h0);

        // Reset during the 8th sample, then a fresh frame
        for (int i = 0; i < 7; i++) push_sample(8'(8'h60 + i));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h67;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_outputs("midrst");
        for (int i = 0; i < 16; i++) push_sample(8'(5 * i + 2));
        check("rs_ready", 32'(bus.frame_ready), 32'h1);
        check("rs_sum", 32'(bus.sum), 32'h278);
        check_max(8'h4D, 4'd15);
        read(4'd0, 8'h02);
        read(4'd7, 8'h25);
        read(4'd15, 8'h4D);
        tick();
        do_clear();

        // clear together with in_valid mid-capture
        push_sample(8'h11); push_sample(8'h22); push_sample(8'h33);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        tick();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("cv_busy", 32'(bus.busy), 32'h0);
        check("cv_ready", 32'(bus.frame_ready), 32'h0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        tick();
        bus.rd_en = 1'b0;
        check("cv_idle_rdvalid", 32'(bus.rd_valid), 32'h0);
        check("cv_idle_rddata", 32'(bus.rd_data), 32'h4D);
        for (int i = 0; i < 16; i++) push_sample(8'(8'h80 + i));
        check("cv_sum", 32'(bus.sum), 32'h878);
        read(4'd0, 8'h80);
        read(4'd3, 8'h83);
        tick();
        tick();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL rd_missing: %0d reads outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p2p_result_collector.md
P2P_RESULT_COLLECTOR -- requirements
Module: p2p_result_collector

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, meaning the number of products per frame (power of two, 2..256).
REQ-002 The block SHALL have parameter DW, default 8, meaning the product width in bits.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, width 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, width 1, meaning in_data holds a product this cycle.
REQ-006 The block SHALL have port in_data, input, width DW, the upstream product (multiplier cout).
REQ-007 The block SHALL have port in_done, input, width 1, the upstream frame-complete flag (level).
REQ-008 The block SHALL have port clear, input, width 1, which releases the captured frame and returns the block to IDLE.
REQ-009 The block SHALL have ports rd_en (input, 1), rd_addr (input, log2(SIZE)), rd_data (output, DW) and rd_valid (output, 1), forming the result read port.
REQ-010 The block SHALL have port sum, output, width DW+log2(SIZE), the exact frame sum.
REQ-011 The block SHALL have ports frame_ready, busy, short_err and overrun_err (outputs, width 1 each), which are status flags.

Function
REQ-012 The block SHALL implement states IDLE, CAPTURE and DONE.
REQ-013 In IDLE, in_valid SHALL store in_data at index 0, set count=1, load sum with in_data and move to CAPTURE.
REQ-014 In CAPTURE, each in_valid SHALL store in_data at index count, increment count and add in_data to sum.
REQ-015 When the SIZE-th sample is stored, the next state SHALL be DONE and frame_ready SHALL be 1 from the following cycle.
REQ-016 If in_done is seen in CAPTURE with count<SIZE and no in_valid that cycle, the block SHALL move to DONE and set short_err; unfilled entries SHALL read 0.
REQ-017 in_valid in DONE SHALL be dropped and SHALL set overrun_err (sticky until clear or rst).
REQ-018 busy SHALL be 1 in CAPTURE, otherwise 0.
REQ-019 sum SHALL be an exact unsigned sum with no truncation; it is meaningful only while frame_ready=1.
REQ-020 In DONE, rd_en SHALL return buffer[rd_addr] on rd_data with rd_valid=1 one cycle later.
REQ-021 rd_en outside DONE SHALL give rd_valid=0 and leave rd_data unchanged.
REQ-022 clear SHALL move any state to IDLE next cycle, zero count, frame_ready and both error flags.
REQ-023 If clear and in_valid are both high, clear SHALL win and the sample SHALL be dropped.
REQ-024 A new frame SHALL be accepted in the cycle after clear.

Reset
REQ-025 rst SHALL force IDLE, count=0, sum=0, rd_data=0, rd_valid=0, frame_ready=0, busy=0, short_err=0 and overrun_err=0, including mid-frame.
REQ-026 Buffer contents SHALL be zeroed by rst or by entering IDLE; they SHALL never be observable before written in the current frame.

Configuration
REQ-027 With macro P2P_COLLECT_MAX_EN defined, the block SHALL add outputs max_val (DW) and max_idx (log2(SIZE)), tracking the largest product and its lowest index, both valid with frame_ready.
REQ-028 With P2P_COLLECT_MAX_EN undefined, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package p2p_pkg SHALL hold the state enum (IDLE/CAPTURE/DONE), the SIZE/DW defaults and a SUM_W = DW+$clog2(SIZE) constant.
REQ-030 The result storage SHALL be one sub-module p2p_result_buf: SIZE x DW, single write port, registered read port, synchronous clear.

Verification
REQ-031 Bench: 16 valids with data 1..16 -> frame_ready after the 16th, sum=0x088, reads at addr 0/15 -> 0x01/0x10 with 1-cycle rd_valid.
REQ-032 Bench: 16 valids of 0xFF -> sum=0xFF0 (no overflow); with MAX_EN, max_val=0xFF and max_idx=0.
REQ-033 Bench: 5 valids, then in_done -> DONE, short_err=1, sum = sum of 5, addr 7 reads 0x00.
REQ-034 Bench: full frame, then extra in_valid 0x55 -> overrun_err=1, buffer and sum unchanged; clear -> IDLE, flags 0.
REQ-035 Bench: rst during the 8th sample -> all outputs at reset values next cycle; a new 16-sample frame is then captured correctly.
REQ-036 Bench: clear and in_valid high together in CAPTURE -> sample dropped, IDLE, count=0; rd_en in IDLE -> rd_valid=0.
